// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock parametrised FIFO that carries coefficient and sample words
//   from the FIR input stage to the tap MAC engine.
//   It supports simultaneous read and write, an occupancy count,
//   almost-full and almost-empty thresholds, sticky overflow and underflow
//   flags, and a synchronous flush.
//   Read behaviour is either a registered read with one cycle of latency
//   (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Ports
//   clk            rising-edge clock
//   rstn           asynchronous active-low reset
//   clr            synchronous flush, active high; overrides read/write
//   in_write_ctrl  write request
//   in_write_data  write data
//   in_read_ctrl   read / pop request
//   out_read_data  read data
//   out_read_valid qualifier for out_read_data
//   full, empty, almost_full, almost_empty  occupancy status
//   count          words stored, 0 .. 2**DEPTH_BITS
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
module sync_fifo_param #(
  parameter int DATABITS   = 16,
  parameter int DEPTH_BITS = 6,
  parameter int AF_THRESH  = 60,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  in_write_ctrl,
  input  logic [DATABITS-1:0]   in_write_data,
  input  logic                  in_read_ctrl,
  output logic [DATABITS-1:0]   out_read_data,
  output logic                  out_read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] C_DEPTH = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] C_AF    = (DEPTH_BITS + 1)'(AF_THRESH);
  localparam logic [DEPTH_BITS:0] C_AE    = (DEPTH_BITS + 1)'(AE_THRESH);
  localparam logic [DEPTH_BITS:0] C_ONE   = (DEPTH_BITS + 1)'(1);

  logic [DATABITS-1:0]   r_mem [DEPTH];
  logic [DEPTH_BITS:0]   r_wr_ptr;
  logic [DEPTH_BITS:0]   r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [DEPTH_BITS:0]   w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DEPTH_BITS-1:0] w_wr_addr;
  logic [DEPTH_BITS-1:0] w_rd_addr;

  // Pointers carry one extra bit.
  // Their difference is the occupancy, so a full FIFO and an empty FIFO
  // never alias, and the pointers wrap naturally.
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == C_DEPTH);
  assign w_empty   = (w_count == '0);
  assign w_wr_acc  = in_write_ctrl & ~w_full;
  assign w_rd_acc  = in_read_ctrl & ~w_empty;
  assign w_wr_addr = r_wr_ptr[DEPTH_BITS-1:0];
  assign w_rd_addr = r_rd_ptr[DEPTH_BITS-1:0];

  assign count        = w_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= C_AF);
  assign almost_empty = (w_count <= C_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // The storage array has no reset, so it can map onto RAM.
  // A flush discards the write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !clr) begin
      r_mem[w_wr_addr] <= in_write_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (in_write_ctrl && w_full)  r_overflow  <= 1'b1;
      if (in_read_ctrl  && w_empty) r_underflow <= 1'b1;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATABITS-1:0] r_rd_data;
      logic                r_rd_valid;

      // The data register holds its last value between pops.
      // Only the valid bit pulses.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (clr) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (w_rd_acc) begin
          r_rd_data  <= r_mem[w_rd_addr];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      assign out_read_data  = r_rd_data;
      assign out_read_valid = r_rd_valid;
    end else begin : g_fwft
      // The head word is always presented.
      // A read request acknowledges it and advances the read pointer.
      assign out_read_data  = r_mem[w_rd_addr];
      assign out_read_valid = ~w_empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW    = 16;
  localparam int DB    = 6;
  localparam int DEPTH = 64;
  localparam int AF    = 60;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clr;
  logic          w;
  logic [DW-1:0] wd;
  logic          r;

  logic [DW-1:0] d0, d1;
  logic          v0, v1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic          ov0, ov1, un0, un1;
  logic [DB:0]   cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: a queue of stored words plus sticky flags.
  // The registered-read output pair of the FWFT=0 instance is modelled alongside.
  logic [DW-1:0] q[$];
  bit            m_ov, m_un, m_v;
  logic [DW-1:0] m_d;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATABITS(DW), .DEPTH_BITS(DB), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
    .clk(clk), .rstn(rstn), .clr(clr),
    .in_write_ctrl(w), .in_write_data(wd), .in_read_ctrl(r),
    .out_read_data(d0), .out_read_valid(v0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_param #(.DATABITS(DW), .DEPTH_BITS(DB), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
    .clk(clk), .rstn(rstn), .clr(clr),
    .in_write_ctrl(w), .in_write_data(wd), .in_read_ctrl(r),
    .out_read_data(d1), .out_read_valid(v1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 0;
    m_un = 0;
    m_v  = 0;
    m_d  = '0;
  endtask

  // Apply one clock edge to the model, using the pre-edge occupancy.
  task automatic model_step(input bit wv, input logic [DW-1:0] dv, input bit rv, input bit cv);
    bit was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (cv) begin
      model_reset();
    end else begin
      if (wv && was_full)  m_ov = 1;
      if (rv && was_empty) m_un = 1;
      if (rv && !was_empty) begin
        m_d = q.pop_front();
        m_v = 1;
      end else begin
        m_v = 0;
      end
      if (wv && !was_full) q.push_back(dv);
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge).
  // Update the model at the rising edge, then return at the next falling edge.
  task automatic cycle(input bit wv, input logic [DW-1:0] dv, input bit rv, input bit cv);
    w   = wv;
    wd  = dv;
    r   = rv;
    clr = cv;
    @(posedge clk);
    model_step(wv, dv, rv, cv);
    @(negedge clk);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : compare
    int n;
    n = q.size();
    chk("count0", 32'(cnt0), n);
    chk("count1", 32'(cnt1), n);
    chk("full0", 32'(full0), 32'(n == DEPTH));
    chk("full1", 32'(full1), 32'(n == DEPTH));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("afull0", 32'(af0), 32'(n >= AF));
    chk("afull1", 32'(af1), 32'(n >= AF));
    chk("aempty0", 32'(ae0), 32'(n <= AE));
    chk("aempty1", 32'(ae1), 32'(n <= AE));
    chk("ovf0", 32'(ov0), 32'(m_ov));
    chk("ovf1", 32'(ov1), 32'(m_ov));
    chk("unf0", 32'(un0), 32'(m_un));
    chk("unf1", 32'(un1), 32'(m_un));
    chk("valid0", 32'(v0), 32'(m_v));
    chk("data0", 32'(d0), 32'(m_d));
    chk("valid1", 32'(v1), 32'(n != 0));
    if (n != 0) chk("data1", 32'(d1), 32'(q[0]));
  end

  initial begin
    int pw, pr;
    rstn = 1'b0;
    clr  = 1'b0;
    w    = 1'b0;
    wd   = '0;
    r    = 1'b0;
    model_reset();
    #12 rstn = 1'b1;
    @(negedge clk);

    // Fill with 0..63, then one write too many.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, DW'(i), 0, 0);
      chk("fill_afull", 32'(af0), 32'((i + 1) >= 60));
    end
    chk("fill_count_lit", 32'(cnt0), 32'd64);
    chk("fill_full_lit", 32'(full0), 32'd1);
    cycle(1, 16'hFFFF, 0, 0);
    chk("ovf_lit", 32'(ov0), 32'd1);
    chk("ovf_count_lit", 32'(cnt0), 32'd64);

    // Drain 64 words; each appears one cycle after its read.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, '0, 1, 0);
      chk("drain_data_lit", 32'(d0), i);
      chk("drain_valid_lit", 32'(v0), 32'd1);
      chk("drain_aempty", 32'(ae0), 32'((63 - i) <= 4));
    end
    cycle(0, '0, 1, 0);
    chk("unf_lit", 32'(un0), 32'd1);
    chk("unf_valid_lit", 32'(v0), 32'd0);

    // Preload 10, then 100 cycles of concurrent read and write.
    for (int i = 0; i < 10; i++) cycle(1, DW'(16'h100 + i), 0, 0);
    for (int i = 10; i < 110; i++) cycle(1, DW'(16'h100 + i), 1, 0);
    chk("conc_count_lit", 32'(cnt0), 32'd10);
    chk("conc_data_lit", 32'(d0), 32'h163);

    // Boundary: read and write together at full, then at empty.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(16'h200 + i), 0, 0);
    cycle(1, 16'hBEEF, 1, 0);
    chk("rw_full_count_lit", 32'(cnt0), 32'd63);
    chk("rw_full_ovf_lit", 32'(ov0), 32'd1);
    for (int i = 0; i < 63; i++) cycle(0, '0, 1, 0);
    cycle(1, 16'h1234, 1, 0);
    chk("rw_empty_count_lit", 32'(cnt0), 32'd1);
    chk("rw_empty_unf_lit", 32'(un0), 32'd1);
    chk("rw_empty_valid_lit", 32'(v0), 32'd0);

    // Flush with read+write pending in the same cycle.
    for (int i = 0; i < 20; i++) cycle(1, DW'($urandom), 0, 0);
    cycle(1, 16'h5555, 1, 1);
    chk("clr_count_lit", 32'(cnt0), 32'd0);
    chk("clr_empty_lit", 32'(empty0), 32'd1);
    chk("clr_ovf_lit", 32'(ov0), 32'd0);
    chk("clr_unf_lit", 32'(un0), 32'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 20; i++) cycle(1, DW'($urandom), (i % 3) == 0, 0);
    cycle(1, 16'h7777, 1, 0);
    w  = 1'b1;
    r  = 1'b1;
    wd = 16'h4242;
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_count_lit", 32'(cnt0), 32'd0);
    chk("arst_empty_lit", 32'(empty1), 32'd1);
    chk("arst_valid_lit", 32'(v0), 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    w = 1'b0;
    r = 1'b0;
    @(negedge clk);

    // First-word-fall-through: the head word appears without a read.
    cycle(1, 16'hA5A5, 0, 0);
    chk("fwft_valid_lit", 32'(v1), 32'd1);
    chk("fwft_data_lit", 32'(d1), 32'hA5A5);
    cycle(0, '0, 1, 0);
    chk("fwft_pop_empty_lit", 32'(empty1), 32'd1);
    chk("fwft_pop_d0_lit", 32'(d0), 32'hA5A5);

    // Random traffic with shifting read/write bias and rare flushes.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 300) == 0) begin
        pw = $urandom_range(90, 10);
        pr = $urandom_range(90, 10);
      end
      cycle($urandom_range(99) < pw, DW'($urandom), $urandom_range(99) < pr,
            $urandom_range(255) == 0);
    end

    w   = 1'b0;
    r   = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
